// File: rtl/pac_dir_ctrl.sv
// pac_dir_ctrl: debounced direction buttons -> registered Pacman direction
// command, with a one-entry buffer for turns that are not yet possible.
module pac_dir_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  scene,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [0:89] map,
    input  logic [4:0]  map_pac_x,
    input  logic [4:0]  map_pac_y,
    output logic [1:0]  pac_dir,
    output logic        dir_pending,
    output logic [1:0]  pending_dir
);

    // Direction codes double as button indices (0 up, 1 down, 2 left, 3 right)
    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [1:0] SCENE_START = 2'b00;
    localparam logic [1:0] SCENE_PLAY  = 2'b01;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0] btn_raw;
    logic [3:0] press;

    assign btn_raw = {btn_right, btn_left, btn_down, btn_up};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic             s1_q, s1_d;
            logic             s2_q, s2_d;
            logic             stable_q, stable_d;
            logic             prev_stable_q, prev_stable_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;

            // Synchronise, then toggle the stable state only after the synced
            // level has disagreed with it for DEBOUNCE_CYCLES consecutive cycles
            always_comb begin
                s1_d          = btn_raw[gi];
                s2_d          = s1_q;
                prev_stable_d = stable_q;
                stable_d      = stable_q;
                cnt_d         = cnt_q;
                if (s2_q == stable_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    stable_d = ~stable_q;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // Debouncer state registers
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q          <= 1'b0;
                    s2_q          <= 1'b0;
                    stable_q      <= 1'b0;
                    prev_stable_q <= 1'b0;
                    cnt_q         <= '0;
                end else begin
                    s1_q          <= s1_d;
                    s2_q          <= s2_d;
                    stable_q      <= stable_d;
                    prev_stable_q <= prev_stable_d;
                    cnt_q         <= cnt_d;
                end
            end

            // Rising edge of the debounced level is a one-cycle press
            assign press[gi] = stable_q & ~prev_stable_q;
        end
    endgenerate

    logic [6:0] idx_here, idx_up, idx_down, idx_left, idx_right;
    logic       pos_ok, can_up, can_down, can_left, can_right;
    logic [3:0] legal_v;

    // Neighbour legality; indices fall back to 0 whenever the neighbour is
    // off-board so the map is never read out of range
    always_comb begin
        idx_here  = {2'b00, map_pac_x} + ({2'b00, map_pac_y} * 7'd18);
        pos_ok    = (map_pac_x <= 5'd17) && (map_pac_y <= 5'd4);
        can_up    = pos_ok && (map_pac_y != 5'd0);
        can_down  = pos_ok && (map_pac_y < 5'd4);
        can_left  = pos_ok && (map_pac_x != 5'd0);
        can_right = pos_ok && (map_pac_x < 5'd17);
        idx_up    = can_up    ? (idx_here - 7'd18) : 7'd0;
        idx_down  = can_down  ? (idx_here + 7'd18) : 7'd0;
        idx_left  = can_left  ? (idx_here - 7'd1)  : 7'd0;
        idx_right = can_right ? (idx_here + 7'd1)  : 7'd0;
        legal_v[DIR_UP]    = can_up    && !map[idx_up];
        legal_v[DIR_DOWN]  = can_down  && !map[idx_down];
        legal_v[DIR_LEFT]  = can_left  && !map[idx_left];
        legal_v[DIR_RIGHT] = can_right && !map[idx_right];
    end

    logic       win_valid;
    logic [1:0] win_dir;

    // Fixed priority among simultaneous presses: up > down > left > right
    always_comb begin
        win_valid = |press;
        if (press[0])      win_dir = DIR_UP;
        else if (press[1]) win_dir = DIR_DOWN;
        else if (press[2]) win_dir = DIR_LEFT;
        else               win_dir = DIR_RIGHT;
    end

    logic [1:0] pac_dir_q, pac_dir_d;
    logic       dir_pending_q, dir_pending_d;
    logic [1:0] pending_dir_q, pending_dir_d;

    // Direction / turn-buffer decision; a fresh press always overrides an
    // older buffered turn
    always_comb begin
        pac_dir_d     = pac_dir_q;
        dir_pending_d = dir_pending_q;
        pending_dir_d = pending_dir_q;
        case (scene)
            SCENE_START: begin
                pac_dir_d     = DIR_LEFT;
                dir_pending_d = 1'b0;
            end
            SCENE_PLAY: begin
                if (win_valid) begin
                    if (win_dir == pac_dir_q) begin
                        dir_pending_d = 1'b0;
                    end else if (legal_v[win_dir]) begin
                        pac_dir_d     = win_dir;
                        dir_pending_d = 1'b0;
                    end else begin
                        pending_dir_d = win_dir;
                        dir_pending_d = 1'b1;
                    end
                end else if (dir_pending_q && legal_v[pending_dir_q]) begin
                    pac_dir_d     = pending_dir_q;
                    dir_pending_d = 1'b0;
                end
            end
            default: begin
                dir_pending_d = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pac_dir_q     <= DIR_LEFT;
            dir_pending_q <= 1'b0;
            pending_dir_q <= DIR_UP;
        end else begin
            pac_dir_q     <= pac_dir_d;
            dir_pending_q <= dir_pending_d;
            pending_dir_q <= pending_dir_d;
        end
    end

    assign pac_dir     = pac_dir_q;
    assign dir_pending = dir_pending_q;
    assign pending_dir = pending_dir_q;

endmodule

// File: tb/tb_pac_dir_ctrl.sv
// Bench for pac_dir_ctrl: per-cycle comparison against a behavioural model
// plus hand-computed expectations at the key points of each scenario.
module tb_pac_dir_ctrl;

    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [1:0]  scene = 2'b01;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic [0:89] map_v = '0;
    logic [4:0]  px = 5'd9, py = 5'd4;
    logic [1:0]  pac_dir;
    logic        dir_pending;
    logic [1:0]  pending_dir;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_en = 1'b0;

    pac_dir_ctrl #(.DEBOUNCE_CYCLES(DB), .CNT_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .scene(scene),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .map(map_v), .map_pac_x(px), .map_pac_y(py),
        .pac_dir(pac_dir), .dir_pending(dir_pending), .pending_dir(pending_dir)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Button b is considered pressed when its debounced level rises; the level
    // flips once the last DB raw samples (seen two cycles late through the
    // synchroniser) all disagree with it.
    function automatic bit legal(int d, int x, int y, logic [0:89] m);
        case (d)
            0:       return (y > 0)  && !m[x + (y - 1) * 18];
            1:       return (y < 4)  && !m[x + (y + 1) * 18];
            2:       return (x > 0)  && !m[x - 1 + y * 18];
            default: return (x < 17) && !m[x + 1 + y * 18];
        endcase
    endfunction

    logic [DB:0] m_hist [4];
    logic [DB:0] n_hist [4];
    logic [3:0]  m_stable, n_stable, m_evt, n_evt, all_diff;
    logic [1:0]  m_dir, n_dir, m_pdir, n_pdir;
    logic        m_pend, n_pend;
    logic [3:0]  raw;
    int          win;

    always_comb begin
        raw      = {btn_right, btn_left, btn_down, btn_up};
        n_dir    = m_dir;
        n_pend   = m_pend;
        n_pdir   = m_pdir;
        n_stable = m_stable;
        n_evt    = '0;
        all_diff = '0;
        win      = -1;
        for (int b = 3; b >= 0; b--) if (m_evt[b]) win = b;
        if (scene == 2'b00) begin
            n_dir  = 2'b10;
            n_pend = 1'b0;
        end else if (scene == 2'b01) begin
            if (win >= 0) begin
                if (win == int'(m_dir)) n_pend = 1'b0;
                else if (legal(win, int'(px), int'(py), map_v)) begin
                    n_dir  = 2'(win);
                    n_pend = 1'b0;
                end else begin
                    n_pdir = 2'(win);
                    n_pend = 1'b1;
                end
            end else if (m_pend && legal(int'(m_pdir), int'(px), int'(py), map_v)) begin
                n_dir  = m_pdir;
                n_pend = 1'b0;
            end
        end else begin
            n_pend = 1'b0;
        end
        for (int b = 0; b < 4; b++) begin
            n_hist[b]   = {m_hist[b][DB-1:0], raw[b]};
            all_diff[b] = 1'b1;
            for (int k = 1; k <= DB; k++)
                if (m_hist[b][k] == m_stable[b]) all_diff[b] = 1'b0;
            if (all_diff[b]) begin
                n_stable[b] = ~m_stable[b];
                n_evt[b]    = ~m_stable[b];
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int b = 0; b < 4; b++) m_hist[b] <= '0;
                m_stable <= '0;
                m_evt    <= '0;
                m_dir    <= 2'b10;
                m_pdir   <= 2'b00;
                m_pend   <= 1'b0;
            end else begin
                for (int b = 0; b < 4; b++) m_hist[b] <= n_hist[b];
                m_stable <= n_stable;
                m_evt    <= n_evt;
                m_dir    <= n_dir;
                m_pdir   <= n_pdir;
                m_pend   <= n_pend;
            end
        end
    end

    // Compare on the falling edge, well away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("cyc_pac_dir", pac_dir, m_dir);
                chk("cyc_dir_pending", {1'b0, dir_pending}, {1'b0, m_pend});
                if (m_pend) chk("cyc_pending_dir", pending_dir, m_pdir);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        step(2);
        #2 rst_n = 1'b1;
        $display("reset: pac_dir=%0d pending=%0b", pac_dir, dir_pending);
    endtask

    task automatic press(input logic [3:0] udlr, input int hold);
        @(negedge clk);
        {btn_up, btn_down, btn_left, btn_right} = udlr;
        step(hold);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        step(8);
        $display("press udlr=%b scene=%0d pos=(%0d,%0d): pac_dir=%0d pending=%0b pending_dir=%0d",
                 udlr, scene, px, py, pac_dir, dir_pending, pending_dir);
    endtask

    initial begin
        // 1. reset with buttons toggling
        #3 rst_n = 1'b0;
        chk_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            {btn_up, btn_down, btn_left, btn_right} = 4'(i * 5 + 3);
        end
        #1;
        chk("rst_pac_dir", pac_dir, 2'b10);
        chk("rst_pending", {1'b0, dir_pending}, 2'b00);
        chk("rst_pending_dir", pending_dir, 2'b00);
        {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(8);
        chk("post_rst_pac_dir", pac_dir, 2'b10);
        chk("post_rst_pending", {1'b0, dir_pending}, 2'b00);
        $display("reset released: pac_dir=%0d pending=%0b", pac_dir, dir_pending);

        // 2. legal press, exact latency
        @(negedge clk);
        btn_up = 1'b1;
        step(6);
        chk("up_edge5", pac_dir, 2'b10);
        step(1);
        chk("up_edge6", pac_dir, 2'b00);
        chk("up_edge6_pending", {1'b0, dir_pending}, 2'b00);
        step(3);
        btn_up = 1'b0;
        step(8);
        $display("press up (9,4): pac_dir=%0d pending=%0b", pac_dir, dir_pending);
        press(4'b1000, 8);
        chk("repress_up", pac_dir, 2'b00);

        // 3. bounce on right
        do_reset();
        @(negedge clk);
        btn_right = 1'b1; step(3);
        btn_right = 1'b0; step(1);
        btn_right = 1'b1; step(3);
        btn_right = 1'b0; step(10);
        $display("bounce right: pac_dir=%0d pending=%0b", pac_dir, dir_pending);
        chk("bounce_pac_dir", pac_dir, 2'b10);
        chk("bounce_pending", {1'b0, dir_pending}, 2'b00);

        // 4. buffered turn applied when the cell opens
        do_reset();
        map_v[63] = 1'b1;
        press(4'b1000, 8);
        chk("buf_pac_dir", pac_dir, 2'b10);
        chk("buf_pending", {1'b0, dir_pending}, 2'b01);
        chk("buf_pending_dir", pending_dir, 2'b00);
        @(negedge clk);
        px = 5'd10;
        @(negedge clk);
        chk("buf_applied", pac_dir, 2'b00);
        chk("buf_cleared", {1'b0, dir_pending}, 2'b00);
        $display("move to (10,4): pac_dir=%0d pending=%0b", pac_dir, dir_pending);

        //    left at the x=0 boundary stays pending
        do_reset();
        map_v = '0;
        px = 5'd0;
        press(4'b1000, 8);
        chk("x0_up", pac_dir, 2'b00);
        press(4'b0010, 8);
        step(12);
        chk("x0_left_dir", pac_dir, 2'b00);
        chk("x0_left_pending", {1'b0, dir_pending}, 2'b01);
        chk("x0_left_pending_dir", pending_dir, 2'b10);

        // 6a. start scene flushes the pending turn
        @(negedge clk);
        scene = 2'b00;
        @(negedge clk);
        chk("start_pac_dir", pac_dir, 2'b10);
        chk("start_pending", {1'b0, dir_pending}, 2'b00);
        $display("scene start: pac_dir=%0d pending=%0b", pac_dir, dir_pending);

        // 6b. win scene ignores presses; a held button across scene change is no press
        scene = 2'b10;
        press(4'b1000, 8);
        chk("win_ignore", pac_dir, 2'b10);
        @(negedge clk);
        btn_down = 1'b1;
        step(8);
        scene = 2'b01;
        step(4);
        btn_down = 1'b0;
        step(8);
        chk("held_across_dir", pac_dir, 2'b10);
        chk("held_across_pending", {1'b0, dir_pending}, 2'b00);
        $display("held down across scene change: pac_dir=%0d pending=%0b", pac_dir, dir_pending);

        // 5. priority up > right
        do_reset();
        px = 5'd9;
        press(4'b1001, 8);
        chk("prio_legal", pac_dir, 2'b00);
        do_reset();
        map_v[63] = 1'b1;
        press(4'b1001, 8);
        chk("prio_blocked_dir", pac_dir, 2'b10);
        chk("prio_blocked_pending", {1'b0, dir_pending}, 2'b01);
        chk("prio_blocked_pending_dir", pending_dir, 2'b00);

        // 6c. reset during a debounce loses the press
        do_reset();
        map_v = '0;
        @(negedge clk);
        btn_up = 1'b1;
        step(3);
        #2 rst_n = 1'b0;
        btn_up = 1'b0;
        step(2);
        #2 rst_n = 1'b1;
        step(10);
        chk("mid_rst_dir", pac_dir, 2'b10);
        chk("mid_rst_pending", {1'b0, dir_pending}, 2'b00);
        $display("reset mid-debounce: pac_dir=%0d pending=%0b", pac_dir, dir_pending);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pac_dir_ctrl.md
# pac_dir_ctrl

Turns the four Basys3 direction buttons into the 2-bit `pac_dir` command used by the Pacman mover, with debouncing and a one-entry turn buffer. A press toward an open cell takes effect immediately. A press toward a wall or the boundary is held as pending and applied on the first cycle it becomes legal, so the player can pre-turn before reaching a junction. It sits between the board buttons and the Pacman mover, and reads the same 18x5 wall map and Pacman position the mover uses.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000 — consecutive cycles a synced button must differ from its stable state before that state toggles (10 ms at 100 MHz).
- `CNT_W`, default 20 — debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- `clk` in 1 — system clock.
- `rst_n` in 1 — reset; one clock, asynchronous, active-low.
- `scene` in 2 — scene code: 00 start, 01 play, 10 win, 11 lose.
- `btn_up`, `btn_down`, `btn_left`, `btn_right` in 1 each — raw asynchronous buttons, active-high.
- `map` in [0:89] — wall map; bit x+y*18 is 1 for a wall.
- `map_pac_x` in 5 — current Pacman column, 0..17.
- `map_pac_y` in 5 — current Pacman row, 0..4.
- `pac_dir` out 2 — direction command: 00 up, 01 down, 10 left, 11 right.
- `dir_pending` out 1 — a buffered turn is waiting.
- `pending_dir` out 2 — the buffered direction; meaningful only while `dir_pending`=1.

## Operation
- **Synchronizer:** each button passes through a 2-flop synchronizer (s1, s2).
- **Debouncer:** one per button, holding a stable bit and a counter.
  - If s2 == stable, the counter clears.
  - Otherwise the counter increments.
  - When the counter == DEBOUNCE_CYCLES-1 and s2 still differs, stable toggles and the counter clears.
- **Press pulse:** one cycle, `press = stable & ~stable_d`. Releases generate nothing.
- **Simultaneous presses:** priority is up > down > left > right. Only the winning press is used.
- **Legality `legal(d)`**, evaluated at the current position (x,y):
  - left: x>0 && !map[x-1+y*18]
  - right: x<17 && !map[x+1+y*18]
  - up: y>0 && !map[x+(y-1)*18]
  - down: y<4 && !map[x+(y+1)*18]
  - Index arithmetic uses at least 7 bits. No out-of-range index is ever read.
- **Play scene (01), press of direction d:**
  - d == `pac_dir`: `dir_pending` is cleared; `pac_dir` is unchanged.
  - legal(d): `pac_dir` takes d and `dir_pending` is cleared.
  - Otherwise: `pending_dir` takes d and `dir_pending` is set. This overwrites any older pending turn.
- **Play scene, no press, `dir_pending`=1:** if legal(`pending_dir`), then `pac_dir` takes `pending_dir` and `dir_pending` is cleared.
- **Start scene (00):** every cycle `pac_dir` takes 10 (left) and `dir_pending` takes 0. Presses are ignored.
- **Win/lose scenes (10/11):** `pac_dir` holds, `dir_pending` takes 0, and presses are ignored.
- **All scenes:** debouncers run continuously. A button held across a scene change yields no new press.
- **Boundaries:** at x=0 left is never legal; at x=17 right; at y=0 up; at y=4 down. These presses go to pending.

## Timing
- **Reset values:**
  - `pac_dir`=10, `dir_pending`=0, `pending_dir`=00.
  - All sync flops, stable bits, `stable_d` and counters are 0.
- **Reset mid-operation:** asynchronous assertion clears everything immediately, including partially counted debounces.
- **Press latency:** counting edge 0 as the first edge sampling a raw button high, and with the button held:
  - s1=1 at edge 0 and s2=1 at edge 1.
  - stable rises at edge DEBOUNCE_CYCLES+1.
  - `pac_dir` (or `dir_pending`) updates at edge DEBOUNCE_CYCLES+2.
- **Bounce rejection:** any low glitch before the toggle restarts the count.
- **Buffered-turn latency:** a pending turn applies on the clock edge after legality becomes true, i.e. one cycle after the position or map change is visible on the inputs.
- **Press vs. buffered turn in the same cycle:** the press wins and the older pending turn is discarded or replaced.
- **Throughput:** one press per button per debounce period. All outputs are registered.

## Test plan
Benches use DEBOUNCE_CYCLES=4. "Empty map" means all-zero `map`.

1. **Reset:** hold `rst_n`=0 with buttons toggling -> `pac_dir`=10, `dir_pending`=0, `pending_dir`=00. Release: outputs unchanged with no buttons pressed.
2. **Legal press:** scene=01, position (9,4), empty map, `btn_up` high 10 cycles -> `pac_dir`=00 exactly at edge 6, `dir_pending`=0. Release and re-press `btn_up` -> no change.
3. **Bounce:** `btn_right` high 3 cycles, low 1, high 3, low -> `pac_dir` stays 10, no pending.
4. **Buffered turn:** position (9,4), map[63]=1, press up -> `pac_dir`=10, `dir_pending`=1, `pending_dir`=00. Drive `map_pac_x`=10 (map[64]=0) -> next edge `pac_dir`=00, `dir_pending`=0. Separately, press left at x=0 -> pending, never applied while x stays 0.
5. **Priority:** `btn_up` and `btn_right` rise on the same cycle, both legal -> `pac_dir`=00. Repeat with up blocked -> `pending_dir`=00, right discarded.
6. **Scene handling:** while pending, scene goes to 00 -> `pac_dir`=10 and `dir_pending`=0 next edge. In scene 10, a press -> no change. Assert `rst_n` mid-debounce -> the press is lost after release.
